tb_core_data_demux: RTL and testbench
=====================================

# tb_core_data_demux

Sequential demultiplexer between the zero-riscy data port and the testbench memory targets: peripheral (HWPE register file), stack memory, and shared TCDM port `MP`. It replaces the combinational bindings with address-decoded request routing, in-order response steering via an outstanding-target FIFO, and a local end-of-computation mailbox at 0x8000_0000. The mailbox exposes the returned error code to the bench.

## Interface
Parameters:
- `HWPE_ADDR_BASE_BIT`, 20: address bit selecting the peripheral target.
- `MAX_OUTSTANDING`, 2: depth of the outstanding-target FIFO (≥1).
- `EOC_ADDR`, 32'h8000_0000: word address of the end-of-computation mailbox.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `data_req_i` in 1: core request.
- `data_gnt_o` out 1: grant to core.
- `data_we_i` in 1: core write, active high.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: byte address.
- `data_wdata_i` in 32: write data.
- `data_rvalid_o` out 1: response valid.
- `data_rdata_o` out 32: response data.
- `slv_req_o` out 3: per-target request. Index 0 is periph, 1 is stack, 2 is tcdm.
- `slv_add_o` out 3x32: address; tcdm gets {8'b0, addr[23:0]}.
- `slv_wen_o` out 3: write enable, active low (~data_we_i).
- `slv_be_o` out 3x4: byte enables.
- `slv_data_o` out 3x32: write data.
- `slv_gnt_i` in 3: per-target grant.
- `slv_r_valid_i` in 3: per-target response valid.
- `slv_r_data_i` in 3x32: per-target response data.
- `eoc_o` out 1: mailbox has been written.
- `returned_o` out 32: mailbox value.
- `protocol_err_o` out 1: sticky unexpected-response flag.
- `perf_cnt_o` out 4x32: per-target accepted-request counters (see Configuration).

## Operation
- Decode order, first match wins:
  - addr == EOC_ADDR gives LOCAL (id 3).
  - addr[HWPE_ADDR_BASE_BIT] gives periph (0).
  - addr[31:24] == 0 gives stack (1).
  - Otherwise tcdm (2).
- Request forwarding:
  - `slv_req_o[t]` = data_req_i & target==t & ~fifo_full.
  - All other slv fields are driven for every target regardless of selection.
- Grant:
  - `data_gnt_o` = ~fifo_full & data_req_i & (target==LOCAL ? 1 : slv_gnt_i[target]).
  - fifo_full is taken from the registered count, so no same-cycle pop→grant path exists.
- FIFO:
  - Push target id on data_req_i & data_gnt_o.
  - Pop when the head response is delivered.
- Response steering:
  - If head is slave t, `data_rvalid_o` = slv_r_valid_i[t] and `data_rdata_o` = slv_r_data_i[t].
  - If head is LOCAL, `data_rvalid_o`=1 in the first cycle the entry is head, and `data_rdata_o` = mailbox.
- Mailbox:
  - A LOCAL write updates `returned_o` on the grant edge, honouring be_i bytewise.
  - The same write sets `eoc_o`, which stays set until reset.
  - A LOCAL read returns the current mailbox value.
- Errors: any slv_r_valid_i[t] with t≠head, or with the FIFO empty, sets `protocol_err_o`. That response is dropped and the FIFO is untouched.

## Timing
- Reset values:
  - FIFO empty; `data_rvalid_o` 0; `eoc_o` 0.
  - `returned_o` 32'hFFFF_FFFF; `protocol_err_o` 0; `perf_cnt_o` all 0.
- Grant is combinational from slave grant, adding zero cycles.
- Response latency equals the slave latency.
- LOCAL response arrives exactly 1 cycle after grant when the FIFO was empty. Otherwise it arrives 1 cycle after the preceding entry pops.
- FIFO full: no grant and no slv_req; the request is held by the core. A pop in that cycle frees a slot next cycle.
- Simultaneous push and pop leaves count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction:
  - FIFO and mailbox are cleared asynchronously.
  - A slave response arriving after reset with an empty FIFO sets `protocol_err_o`.

## Configuration
- `TB_CORE_DEMUX_PERF_EN` defined:
  - `perf_cnt_o[t]` increments on each granted request to target t (index 3 = LOCAL).
  - Counters are 32-bit, saturating at 32'hFFFF_FFFF.
- Not defined: `perf_cnt_o` is tied to 0 and no counter flops exist.

## Test plan
- Read 0x0000_0100 (stack), then read 0x1000_0040 (tcdm), each slave answering 1 cycle after grant. Expected: tcdm sees add 0x0000_0040, and responses return in order with the correct data.
- Write 0x0000_0000 to 0x8000_0000, be 4'hF. Expected: no slv_req; `eoc_o`=1 and `returned_o`=0 next cycle; rvalid 1 cycle after grant.
- With MAX_OUTSTANDING=2, issue 3 back-to-back stack reads, slave responding after 5 cycles. Expected: the third request sees gnt=0 until the first response pops.
- Issue a stack read (head) and a periph read, with periph responding first. Expected: `protocol_err_o`=1; the stack response still routes correctly.
- Assert reset with 2 transactions outstanding. Expected: FIFO empties, `returned_o`=0xFFFF_FFFF, and a late slave r_valid sets `protocol_err_o`.
- With `TB_CORE_DEMUX_PERF_EN`, run 4 tcdm writes and 1 LOCAL write. Expected: perf_cnt_o[2]=4 and perf_cnt_o[3]=1.

Source files
------------

// File: rtl/tb_core_data_demux.sv
// Data-port demultiplexer for the zero-riscy bench: routes core requests to periph/stack/tcdm or a local
// end-of-computation mailbox, and steers responses back in order. Optional counters: TB_CORE_DEMUX_PERF_EN.
module tb_core_data_demux #(
  parameter int unsigned HWPE_ADDR_BASE_BIT = 20,
  parameter int unsigned MAX_OUTSTANDING    = 2,
  parameter logic [31:0] EOC_ADDR           = 32'h8000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic [2:0]       slv_req_o,
  output logic [2:0][31:0] slv_add_o,
  output logic [2:0]       slv_wen_o,
  output logic [2:0][3:0]  slv_be_o,
  output logic [2:0][31:0] slv_data_o,
  input  logic [2:0]       slv_gnt_i,
  input  logic [2:0]       slv_r_valid_i,
  input  logic [2:0][31:0] slv_r_data_i,
  output logic             eoc_o,
  output logic [31:0]      returned_o,
  output logic             protocol_err_o,
  output logic [3:0][31:0] perf_cnt_o
);

  typedef enum logic [1:0] {
    TGT_PERIPH = 2'd0,
    TGT_STACK  = 2'd1,
    TGT_TCDM   = 2'd2,
    TGT_LOCAL  = 2'd3
  } target_e;

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  target_e            w_target;
  target_e            w_head;
  target_e            r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_slv_gnt_sel;
  logic               w_push;
  logic               w_pop;
  logic [2:0]         w_stray;
  logic [31:0]        r_returned;
  logic               r_eoc;
  logic               r_protocol_err;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode priority: mailbox word first, then peripheral bit, then low 16 MiB as stack.
  always_comb begin
    w_target = TGT_TCDM;
    if (data_addr_i == EOC_ADDR)                 w_target = TGT_LOCAL;
    else if (data_addr_i[HWPE_ADDR_BASE_BIT])    w_target = TGT_PERIPH;
    else if (data_addr_i[31:24] == 8'h00)        w_target = TGT_STACK;
  end

  // Full comes from the registered count only, so a pop never unblocks a grant in the same cycle.
  assign w_full   = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty  = (r_count == '0);
  assign w_accept = data_req_i & ~w_full;

  always_comb begin
    w_slv_gnt_sel = 1'b1;
    case (w_target)
      TGT_PERIPH: w_slv_gnt_sel = slv_gnt_i[0];
      TGT_STACK:  w_slv_gnt_sel = slv_gnt_i[1];
      TGT_TCDM:   w_slv_gnt_sel = slv_gnt_i[2];
      default:    w_slv_gnt_sel = 1'b1;
    endcase
  end

  assign data_gnt_o = w_accept & w_slv_gnt_sel;
  assign w_push     = data_gnt_o;

  assign slv_req_o[0] = w_accept & (w_target == TGT_PERIPH);
  assign slv_req_o[1] = w_accept & (w_target == TGT_STACK);
  assign slv_req_o[2] = w_accept & (w_target == TGT_TCDM);

  assign slv_add_o[0] = data_addr_i;
  assign slv_add_o[1] = data_addr_i;
  assign slv_add_o[2] = {8'h00, data_addr_i[23:0]};
  assign slv_wen_o    = {3{~data_we_i}};
  assign slv_be_o     = {3{data_be_i}};
  assign slv_data_o   = {3{data_wdata_i}};

  assign w_head = r_fifo[r_rptr];

  // Only the head target may answer; anything else is flagged and discarded.
  always_comb begin
    data_rvalid_o = 1'b0;
    data_rdata_o  = r_returned;
    w_stray       = slv_r_valid_i;
    if (!w_empty) begin
      case (w_head)
        TGT_PERIPH: begin
          data_rvalid_o = slv_r_valid_i[0];
          data_rdata_o  = slv_r_data_i[0];
          w_stray[0]    = 1'b0;
        end
        TGT_STACK: begin
          data_rvalid_o = slv_r_valid_i[1];
          data_rdata_o  = slv_r_data_i[1];
          w_stray[1]    = 1'b0;
        end
        TGT_TCDM: begin
          data_rvalid_o = slv_r_valid_i[2];
          data_rdata_o  = slv_r_data_i[2];
          w_stray[2]    = 1'b0;
        end
        default: data_rvalid_o = 1'b1;
      endcase
    end
  end

  assign w_pop = data_rvalid_o;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_next(r_wptr);
      if (w_pop)  r_rptr <= ptr_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_target;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_returned     <= 32'hFFFF_FFFF;
      r_eoc          <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_push && (w_target == TGT_LOCAL) && data_we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (data_be_i[b]) r_returned[8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
        r_eoc <= 1'b1;
      end
      if (|w_stray) r_protocol_err <= 1'b1;
    end
  end

  assign eoc_o          = r_eoc;
  assign returned_o     = r_returned;
  assign protocol_err_o = r_protocol_err;

`ifdef TB_CORE_DEMUX_PERF_EN
  logic [3:0][31:0] r_perf_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_cnt <= '0;
    end else if (w_push && (r_perf_cnt[w_target] != 32'hFFFF_FFFF)) begin
      r_perf_cnt[w_target] <= r_perf_cnt[w_target] + 32'd1;
    end
  end

  assign perf_cnt_o = r_perf_cnt;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tb_core_data_demux.sv
// Self-checking bench for tb_core_data_demux: directed scenarios plus a randomized run compared
// cycle by cycle against a queue-based model of the routing, ordering and mailbox rules.
module tb_tb_core_data_demux;

  localparam int          MAX_OUT = 2;
  localparam logic [31:0] EOC     = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req, we;
  logic [3:0]       be;
  logic [31:0]      addr, wdata;
  logic [2:0]       sgnt, srv;
  logic [2:0][31:0] srd;

  logic             gnt, rvalid, eoc, perr;
  logic [31:0]      rdata, returned;
  logic [2:0]       sreq, swen;
  logic [2:0][31:0] sadd, sdata;
  logic [2:0][3:0]  sbe;
  logic [3:0][31:0] perf;

  always #5 clk = ~clk;

  tb_core_data_demux #(
    .HWPE_ADDR_BASE_BIT(20),
    .MAX_OUTSTANDING   (MAX_OUT),
    .EOC_ADDR          (EOC)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_req_i    (req),
    .data_gnt_o    (gnt),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_addr_i   (addr),
    .data_wdata_i  (wdata),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .slv_req_o     (sreq),
    .slv_add_o     (sadd),
    .slv_wen_o     (swen),
    .slv_be_o      (sbe),
    .slv_data_o    (sdata),
    .slv_gnt_i     (sgnt),
    .slv_r_valid_i (srv),
    .slv_r_data_i  (srd),
    .eoc_o         (eoc),
    .returned_o    (returned),
    .protocol_err_o(perr),
    .perf_cnt_o    (perf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of outstanding target ids (3 = mailbox), mailbox value, flags, counters.
  int          q[$];
  logic [31:0] m_mbox;
  bit          m_eoc, m_err;
  int unsigned m_perf[4];
  logic        exp_gnt, exp_rv;
  logic [31:0] exp_rd;
  logic [2:0]  exp_sreq;
  int          cur_tgt;

  function automatic int decode(input logic [31:0] a);
    if (a == EOC)           return 3;
    if (a[20])              return 0;
    if (a[31:24] == 8'h00)  return 1;
    return 2;
  endfunction

  task automatic model_reset();
    q.delete();
    m_mbox = 32'hFFFF_FFFF;
    m_eoc  = 0;
    m_err  = 0;
    for (int t = 0; t < 4; t++) m_perf[t] = 0;
  endtask

  task automatic predict();
    bit full;
    cur_tgt  = decode(addr);
    full     = (q.size() >= MAX_OUT);
    exp_gnt  = req && !full && (cur_tgt == 3 || sgnt[cur_tgt]);
    exp_sreq = 3'b000;
    if (req && !full && cur_tgt != 3) exp_sreq[cur_tgt] = 1'b1;
    exp_rv = 1'b0;
    exp_rd = 32'h0;
    if (q.size() > 0) begin
      if (q[0] == 3) begin
        exp_rv = 1'b1;
        exp_rd = m_mbox;
      end else begin
        exp_rv = srv[q[0]];
        exp_rd = srd[q[0]];
      end
    end
  endtask

  task automatic commit();
    bit pop;
    predict();
    pop = 0;
    if (q.size() > 0) pop = (q[0] == 3) || srv[q[0]];
    for (int t = 0; t < 3; t++)
      if (srv[t] && (q.size() == 0 || t != q[0])) m_err = 1;
    if (pop) void'(q.pop_front());
    if (exp_gnt) begin
      q.push_back(cur_tgt);
      if (m_perf[cur_tgt] != 32'hFFFF_FFFF) m_perf[cur_tgt]++;
      if (cur_tgt == 3 && we) begin
        for (int b = 0; b < 4; b++) if (be[b]) m_mbox[8*b +: 8] = wdata[8*b +: 8];
        m_eoc = 1;
      end
    end
  endtask

  task automatic idle_inputs();
    req = 0; we = 0; be = 4'hF; addr = 32'h0; wdata = 32'h0;
    sgnt = 3'b111; srv = 3'b000; srd = '0;
  endtask

  task automatic tick();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({rvalid, eoc, perr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got rvalid/eoc/err %b required 000", {rvalid, eoc, perr});
    end
    n_checks++;
    if (returned !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL reset_returned: got %h required ffffffff", returned);
    end
    n_checks++;
    if (perf !== '0) begin
      n_fail++; $display("FAIL reset_perf: got %h required 0", perf);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    n_checks++;
    if ({gnt, sreq, rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_idle: got gnt/sreq/rvalid %b required 00000", {gnt, sreq, rvalid});
    end
    tick();
  endtask

  task automatic test_in_order();
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    req = 1; we = 0; be = 4'hF; addr = 32'h0000_0100;
    @(negedge clk);
    n_checks++;
    if ({gnt, sreq} !== 4'b1010 || sadd[1] !== 32'h100 || swen !== 3'b111) begin
      n_fail++; $display("FAIL inorder_stack_req: got gnt/sreq %b add %h wen %b required 1010 00000100 111",
                         {gnt, sreq}, sadd[1], swen);
    end
    tick();
    addr = 32'h1000_0040; srv = 3'b010; srd[1] = d1;
    @(negedge clk);
    n_checks++;
    if ({gnt, sreq} !== 4'b1100 || sadd[2] !== 32'h0000_0040) begin
      n_fail++; $display("FAIL inorder_tcdm_req: got gnt/sreq %b add %h required 1100 00000040", {gnt, sreq}, sadd[2]);
    end
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== d1) begin
      n_fail++; $display("FAIL inorder_rsp1: got rvalid %b data %h required 1 %h", rvalid, rdata, d1);
    end
    tick();
    req = 0; srv = 3'b100; srd[1] = 32'h0; srd[2] = d2;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== d2) begin
      n_fail++; $display("FAIL inorder_rsp2: got rvalid %b data %h required 1 %h", rvalid, rdata, d2);
    end
    tick();
    srv = 3'b000;
    @(negedge clk);
    n_checks++;
    if ({rvalid, perr} !== 2'b00) begin
      n_fail++; $display("FAIL inorder_drain: got rvalid/err %b required 00", {rvalid, perr});
    end
    tick();
  endtask

  task automatic test_eoc();
    req = 1; we = 1; be = 4'hF; addr = EOC; wdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if ({gnt, sreq} !== 4'b1000) begin
      n_fail++; $display("FAIL eoc_grant: got gnt/sreq %b required 1000", {gnt, sreq});
    end
    tick();
    req = 0; we = 0;
    @(negedge clk);
    n_checks++;
    if (eoc !== 1'b1 || returned !== 32'h0) begin
      n_fail++; $display("FAIL eoc_mailbox: got eoc %b returned %h required 1 00000000", eoc, returned);
    end
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL eoc_rsp: got rvalid %b data %h required 1 00000000", rvalid, rdata);
    end
    tick();
    req = 1; we = 1; be = 4'b0101; wdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0 || gnt !== 1'b1) begin
      n_fail++; $display("FAIL eoc_partial_wr: got rvalid %b gnt %b required 0 1", rvalid, gnt);
    end
    tick();
    we = 0; be = 4'hF;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b1 || rvalid !== 1'b1 || returned !== 32'h0034_0078) begin
      n_fail++; $display("FAIL eoc_partial_be: got gnt %b rvalid %b returned %h required 1 1 00340078",
                         gnt, rvalid, returned);
    end
    tick();
    req = 0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0034_0078) begin
      n_fail++; $display("FAIL eoc_local_read: got rvalid %b data %h required 1 00340078", rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back_full();
    logic g, v;
    for (int c = 0; c < 13; c++) begin
      req  = (c <= 6); we = 0; addr = 32'h0000_0300 + 32'(4 * c);
      srv  = (c == 5 || c == 6 || c == 11) ? 3'b010 : 3'b000;
      srd[1] = 32'hC0DE_0000 + 32'(c);
      g = (c == 0 || c == 1 || c == 6);
      v = (c == 5 || c == 6 || c == 11);
      @(negedge clk);
      n_checks++;
      if ({gnt, sreq} !== (g ? 4'b1010 : 4'b0000)) begin
        n_fail++; $display("FAIL full_grant c%0d: got gnt/sreq %b required %b", c, {gnt, sreq}, g ? 4'b1010 : 4'b0000);
      end
      n_checks++;
      if (rvalid !== v || (v && rdata !== srd[1])) begin
        n_fail++; $display("FAIL full_rsp c%0d: got rvalid %b data %h required %b %h", c, rvalid, rdata, v, srd[1]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_protocol_err();
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    req = 1; we = 0; addr = 32'h0000_0200;
    tick();
    addr = 32'h0010_0000;
    @(negedge clk);
    n_checks++;
    if ({gnt, sreq} !== 4'b1001) begin
      n_fail++; $display("FAIL err_periph_req: got gnt/sreq %b required 1001", {gnt, sreq});
    end
    tick();
    req = 0; srv = 3'b001; srd[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fail++; $display("FAIL err_drop: got rvalid %b required 0", rvalid);
    end
    tick();
    srv = 3'b010; srd[1] = d1;
    @(negedge clk);
    n_checks++;
    if (perr !== 1'b1 || rvalid !== 1'b1 || rdata !== d1) begin
      n_fail++; $display("FAIL err_stack_rsp: got err %b rvalid %b data %h required 1 1 %h", perr, rvalid, rdata, d1);
    end
    tick();
    srv = 3'b001; srd[0] = d2;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== d2) begin
      n_fail++; $display("FAIL err_periph_rsp: got rvalid %b data %h required 1 %h", rvalid, rdata, d2);
    end
    tick();
    srv = 3'b000;
    @(negedge clk);
    n_checks++;
    if ({rvalid, perr} !== 2'b01) begin
      n_fail++; $display("FAIL err_sticky: got rvalid/err %b required 01", {rvalid, perr});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 1; we = 1; be = 4'hF; addr = EOC; wdata = $urandom;
    tick();
    we = 0; addr = 32'h0000_0400;
    tick();
    addr = 32'h2000_0000;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b1 || eoc !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_setup: got gnt %b eoc %b required 1 1", gnt, eoc);
    end
    tick();
    req = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if ({rvalid, eoc} !== 2'b00 || returned !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL rstmid_clear: got rvalid/eoc %b returned %h required 00 ffffffff", {rvalid, eoc}, returned);
    end
    @(posedge clk);
    #1 rst_n = 1;
    srv = 3'b010; srd[1] = $urandom;
    @(negedge clk);
    n_checks++;
    if ({rvalid, perr} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_late_rsp: got rvalid/err %b required 00", {rvalid, perr});
    end
    tick();
    srv = 3'b000;
    @(negedge clk);
    n_checks++;
    if (perr !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_err: got err %b required 1", perr);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req = ($urandom % 4) != 0; we = $urandom; be = $urandom; wdata = $urandom;
      sgnt = $urandom; srv = 3'b000;
      for (int t = 0; t < 3; t++) srd[t] = $urandom;
      a = $urandom;
      case ($urandom % 4)
        0:       addr = EOC;
        1:       addr = a | 32'h0010_0000;
        2:       addr = {8'h00, a[23:21], 1'b0, a[19:0]};
        default: begin
          addr = a & ~32'h0010_0000;
          if (addr[31:24] == 8'h00) addr[31:24] = 8'h10;
          if (addr == EOC) addr[0] = 1'b1;
        end
      endcase
      if (q.size() > 0 && q[0] != 3 && ($urandom % 2) == 1) srv[q[0]] = 1'b1;
      @(negedge clk);
      predict();
      n_checks++;
      if ({gnt, sreq} !== {exp_gnt, exp_sreq}) begin
        n_fail++; $display("FAIL rand_req c%0d: got gnt/sreq %b required %b", c, {gnt, sreq}, {exp_gnt, exp_sreq});
      end
      n_checks++;
      if (rvalid !== exp_rv || (exp_rv && rdata !== exp_rd)) begin
        n_fail++; $display("FAIL rand_rsp c%0d: got rvalid %b data %h required %b %h", c, rvalid, rdata, exp_rv, exp_rd);
      end
      n_checks++;
      if (eoc !== m_eoc || returned !== m_mbox || perr !== m_err) begin
        n_fail++; $display("FAIL rand_state c%0d: got eoc %b ret %h err %b required %b %h %b",
                           c, eoc, returned, perr, m_eoc, m_mbox, m_err);
      end
      n_checks++;
      if (sadd[0] !== addr || sadd[1] !== addr || sadd[2] !== {8'h00, addr[23:0]} ||
          swen !== {3{~we}} || sbe !== {3{be}} || sdata !== {3{wdata}}) begin
        n_fail++; $display("FAIL rand_fields c%0d: got add2 %h wen %b required %h %b",
                           c, sadd[2], swen, {8'h00, addr[23:0]}, {3{~we}});
      end
`ifdef TB_CORE_DEMUX_PERF_EN
      n_checks++;
      if (perf !== {m_perf[3], m_perf[2], m_perf[1], m_perf[0]}) begin
        n_fail++; $display("FAIL rand_perf c%0d: got %h required %h", c, perf, {m_perf[3], m_perf[2], m_perf[1], m_perf[0]});
      end
`endif
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_perf();
    logic [31:0] d;
    logic [3:0][31:0] exp_perf;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = 1; we = 1; addr = 32'h3000_0000 + 32'(4 * i); wdata = $urandom;
      @(negedge clk);
      n_checks++;
      if ({gnt, sreq} !== 4'b1100) begin
        n_fail++; $display("FAIL perf_tcdm_wr%0d: got gnt/sreq %b required 1100", i, {gnt, sreq});
      end
      tick();
      req = 0; srv = 3'b100;
      tick();
      srv = 3'b000;
    end
    d = $urandom;
    req = 1; we = 1; addr = EOC; wdata = d;
    tick();
    req = 0; we = 0;
    tick();
`ifdef TB_CORE_DEMUX_PERF_EN
    exp_perf = {32'd1, 32'd4, 32'd0, 32'd0};
`else
    exp_perf = '0;
`endif
    @(negedge clk);
    n_checks++;
    if (perf !== exp_perf) begin
      n_fail++; $display("FAIL perf_counts: got %h required %h", perf, exp_perf);
    end
    n_checks++;
    if (returned !== d || eoc !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL perf_mailbox: got ret %h eoc %b rvalid %b required %h 1 0", returned, eoc, rvalid, d);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_eoc();
    test_back_to_back_full();
    test_protocol_err();
    test_reset_mid();
    test_random();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
